// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared source ids and defaults for the core memory arbiter
package core_mem_pkg;
    typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} mem_src_e;
    localparam int MEM_MAX_OUTSTANDING = 2;
endpackage

// File: rtl/id_fifo.sv
// id_fifo: in-order FIFO holding the source id of each outstanding memory transaction
module id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CAP = CW'(DEPTH);
    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign full = count == CAP;
    assign empty = count == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = store[rd_ptr];
    always_ff @(posedge clk_i) begin
        if (do_push) store[wr_ptr] <= din;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin 2:1 arbiter sharing one req/gnt/rvalid memory port
// between instruction fetch and data, routing responses back in issue order.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_OUTSTANDING = MEM_MAX_OUTSTANDING
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   instr_if_address_i,
    input  logic                    instr_if_data_req_i,
    output logic                    instr_if_data_gnt_o,
    output logic                    instr_if_data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_if_data_rdata_o,
    input  logic [ADDR_WIDTH-1:0]   data_if_address_i,
    input  logic                    data_if_data_req_i,
    input  logic                    data_if_data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_if_data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_if_data_wdata_i,
    output logic                    data_if_data_gnt_o,
    output logic                    data_if_data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_if_data_rdata_o,
    output logic [ADDR_WIDTH-1:0]   mem_address_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    err_o
);
    mem_src_e sel, last_q, lock_src_q, head;
    logic locked_q, full, empty, hs, is_data, head_raw;
    always_comb begin
        sel = SRC_INSTR;
        if (locked_q) sel = lock_src_q;
        else if (instr_if_data_req_i && data_if_data_req_i) begin
            if (last_q == SRC_INSTR) sel = SRC_DATA;
        end else if (data_if_data_req_i) sel = SRC_DATA;
    end
    assign is_data = sel == SRC_DATA;
    assign mem_req_o = (instr_if_data_req_i | data_if_data_req_i) & ~full;
    assign hs = mem_req_o & mem_gnt_i;
    assign instr_if_data_gnt_o = hs & ~is_data;
    assign data_if_data_gnt_o = hs & is_data;
    assign mem_address_o = is_data ? data_if_address_i : instr_if_address_i;
    assign mem_we_o = is_data & data_if_data_we_i;
    assign mem_be_o = is_data ? data_if_data_be_i : '1;
    assign mem_wdata_o = is_data ? data_if_data_wdata_i : '0;
    // Only rvalid is steered; data is shared so the response path stays a wire.
    assign instr_if_data_rdata_o = mem_rdata_i;
    assign data_if_data_rdata_o = mem_rdata_i;
    assign head = mem_src_e'(head_raw);
    assign instr_if_data_rvalid_o = mem_rvalid_i & ~empty & (head == SRC_INSTR);
    assign data_if_data_rvalid_o = mem_rvalid_i & ~empty & (head == SRC_DATA);
    id_fifo #(
        .WIDTH(1),
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push(hs),
        .din(sel),
        .pop(mem_rvalid_i),
        .dout(head_raw),
        .full(full),
        .empty(empty)
    );
    // A stalled request pins its source so the payload cannot change under the memory.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            locked_q <= 1'b0;
            lock_src_q <= SRC_INSTR;
            last_q <= SRC_DATA;
            err_o <= 1'b0;
        end else begin
            if (mem_req_o && !mem_gnt_i) begin
                locked_q <= 1'b1;
                lock_src_q <= sel;
            end else if (hs) locked_q <= 1'b0;
            if (hs) last_q <= sel;
            if (mem_rvalid_i && empty) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed stimulus with a queue scoreboard for grants and responses
module tb_core_mem_arbiter;
    localparam logic SI = 1'b0;
    localparam logic SD = 1'b1;
    localparam logic [63:0] KEY = 64'hA5A5_0000_F0F0_0000;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic [63:0] instr_if_address_i = '0, data_if_address_i = '0, data_if_data_wdata_i = '0;
    logic instr_if_data_req_i = 1'b0, data_if_data_req_i = 1'b0, data_if_data_we_i = 1'b0;
    logic [7:0] data_if_data_be_i = 8'hFF;
    logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic instr_if_data_gnt_o, instr_if_data_rvalid_o, data_if_data_gnt_o, data_if_data_rvalid_o;
    logic [63:0] instr_if_data_rdata_o, data_if_data_rdata_o, mem_address_o, mem_wdata_o;
    logic mem_req_o, mem_we_o, err_o;
    logic [7:0] mem_be_o;
    int checks = 0, errors = 0;
    logic [64:0] exp_gnt[$];
    logic [64:0] exp_rsp[$];
    logic rsp_en = 1'b1, inject_rv = 1'b0;
    logic [63:0] inj_data = '0;

    core_mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_if_address_i(instr_if_address_i), .instr_if_data_req_i(instr_if_data_req_i),
        .instr_if_data_gnt_o(instr_if_data_gnt_o), .instr_if_data_rvalid_o(instr_if_data_rvalid_o),
        .instr_if_data_rdata_o(instr_if_data_rdata_o),
        .data_if_address_i(data_if_address_i), .data_if_data_req_i(data_if_data_req_i),
        .data_if_data_we_i(data_if_data_we_i), .data_if_data_be_i(data_if_data_be_i),
        .data_if_data_wdata_i(data_if_data_wdata_i), .data_if_data_gnt_o(data_if_data_gnt_o),
        .data_if_data_rvalid_o(data_if_data_rvalid_o), .data_if_data_rdata_o(data_if_data_rdata_o),
        .mem_address_o(mem_address_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Memory model: one-cycle read latency, data derived from the granted address.
    initial begin
        logic hs_s;
        logic [63:0] a_s;
        forever begin
            @(negedge clk_i);
            hs_s = mem_req_o & mem_gnt_i;
            a_s = mem_address_o;
            @(posedge clk_i);
            #2;
            mem_rvalid_i = (hs_s & rsp_en) | inject_rv;
            mem_rdata_i = inject_rv ? inj_data : a_s ^ KEY;
        end
    end

    // Monitor: pops the scoreboard whenever a grant or response is presented.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk_i);
            if (instr_if_data_gnt_o | data_if_data_gnt_o) begin
                if (exp_gnt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt: got %b%b expected none", instr_if_data_gnt_o, data_if_data_gnt_o);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt_src", {62'b0, instr_if_data_gnt_o, data_if_data_gnt_o}, e[64] ? 64'd1 : 64'd2);
                    chk("gnt_addr", mem_address_o, e[63:0]);
                end
            end
            if (instr_if_data_rvalid_o | data_if_data_rvalid_o) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got %b%b expected none", instr_if_data_rvalid_o, data_if_data_rvalid_o);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_src", {62'b0, instr_if_data_rvalid_o, data_if_data_rvalid_o}, e[64] ? 64'd1 : 64'd2);
                    chk("rsp_data", e[64] ? data_if_data_rdata_o : instr_if_data_rdata_o, e[63:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        @(negedge clk_i);
        chk("rst_instr_gnt", instr_if_data_gnt_o, 0);
        chk("rst_data_gnt", data_if_data_gnt_o, 0);
        chk("rst_instr_rvalid", instr_if_data_rvalid_o, 0);
        chk("rst_data_rvalid", data_if_data_rvalid_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        rst_i = 1'b0;
        // single fetch
        instr_if_address_i = 64'h1000;
        instr_if_data_req_i = 1'b1;
        mem_gnt_i = 1'b1;
        exp_gnt.push_back({SI, 64'h1000});
        exp_rsp.push_back({SI, 64'h1000 ^ KEY});
        @(negedge clk_i);
        chk("fetch_gnt", instr_if_data_gnt_o, 1);
        chk("fetch_we", mem_we_o, 0);
        chk("fetch_be", mem_be_o, 8'hFF);
        chk("fetch_wdata", mem_wdata_o, 0);
        tick();
        instr_if_data_req_i = 1'b0;
        @(negedge clk_i);
        chk("fetch_rvalid", instr_if_data_rvalid_o, 1);
        chk("fetch_data_rvalid", data_if_data_rvalid_o, 0);
        chk("fetch_rdata", instr_if_data_rdata_o, 64'h1000 ^ KEY);
        tick();
        // continuous conflict from reset: I,D,I,D...
        do_reset();
        instr_if_data_req_i = 1'b1;
        data_if_data_req_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr_if_address_i = 64'h2000 + 64'(8 * ((k + 1) / 2));
            data_if_address_i = 64'h3000 + 64'(8 * (k / 2));
            if (k % 2 == 0) begin
                exp_gnt.push_back({SI, instr_if_address_i});
                exp_rsp.push_back({SI, instr_if_address_i ^ KEY});
            end else begin
                exp_gnt.push_back({SD, data_if_address_i});
                exp_rsp.push_back({SD, data_if_address_i ^ KEY});
            end
            tick();
        end
        instr_if_data_req_i = 1'b0;
        data_if_data_req_i = 1'b0;
        tick();
        tick();
        // stalled data write keeps the lock while instr arrives
        data_if_data_req_i = 1'b1;
        data_if_address_i = 64'h5000;
        data_if_data_we_i = 1'b1;
        data_if_data_be_i = 8'h0F;
        data_if_data_wdata_i = 64'hDEADBEEF;
        mem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("stall1_req", mem_req_o, 1);
        chk("stall1_we", mem_we_o, 1);
        chk("stall1_be", mem_be_o, 8'h0F);
        chk("stall1_wdata", mem_wdata_o, 64'hDEADBEEF);
        tick();
        instr_if_data_req_i = 1'b1;
        instr_if_address_i = 64'h6000;
        @(negedge clk_i);
        chk("stall2_addr", mem_address_o, 64'h5000);
        chk("stall2_we", mem_we_o, 1);
        chk("stall2_be", mem_be_o, 8'h0F);
        chk("stall2_instr_gnt", instr_if_data_gnt_o, 0);
        tick();
        @(negedge clk_i);
        chk("stall3_addr", mem_address_o, 64'h5000);
        chk("stall3_we", mem_we_o, 1);
        tick();
        mem_gnt_i = 1'b1;
        exp_gnt.push_back({SD, 64'h5000});
        exp_rsp.push_back({SD, 64'h5000 ^ KEY});
        @(negedge clk_i);
        chk("stall_end_data_gnt", data_if_data_gnt_o, 1);
        chk("stall_end_we", mem_we_o, 1);
        tick();
        data_if_data_req_i = 1'b0;
        data_if_data_we_i = 1'b0;
        data_if_data_be_i = 8'hFF;
        exp_gnt.push_back({SI, 64'h6000});
        exp_rsp.push_back({SI, 64'h6000 ^ KEY});
        @(negedge clk_i);
        chk("after_stall_instr_gnt", instr_if_data_gnt_o, 1);
        tick();
        instr_if_data_req_i = 1'b0;
        tick();
        tick();
        // memory withholds rvalid: FIFO fills after two handshakes
        rsp_en = 1'b0;
        instr_if_data_req_i = 1'b1;
        instr_if_address_i = 64'h7000;
        exp_gnt.push_back({SI, 64'h7000});
        tick();
        instr_if_address_i = 64'h7008;
        exp_gnt.push_back({SI, 64'h7008});
        tick();
        instr_if_address_i = 64'h7010;
        @(negedge clk_i);
        chk("full_mem_req", mem_req_o, 0);
        chk("full_instr_gnt", instr_if_data_gnt_o, 0);
        tick();
        data_if_data_req_i = 1'b1;
        data_if_address_i = 64'h8000;
        @(negedge clk_i);
        chk("full2_mem_req", mem_req_o, 0);
        chk("full2_data_gnt", data_if_data_gnt_o, 0);
        chk("full2_instr_gnt", instr_if_data_gnt_o, 0);
        tick();
        data_if_data_req_i = 1'b0;
        inject_rv = 1'b1;
        inj_data = 64'hCAFE;
        exp_rsp.push_back({SI, 64'hCAFE});
        @(negedge clk_i);
        chk("full_pop_mem_req", mem_req_o, 0);
        chk("full_pop_rvalid", instr_if_data_rvalid_o, 1);
        tick();
        inject_rv = 1'b0;
        exp_gnt.push_back({SI, 64'h7010});
        @(negedge clk_i);
        chk("refill_instr_gnt", instr_if_data_gnt_o, 1);
        tick();
        instr_if_data_req_i = 1'b0;
        tick();
        // reset with two outstanding, then a fresh fetch
        do_reset();
        rsp_en = 1'b1;
        instr_if_data_req_i = 1'b1;
        instr_if_address_i = 64'h9000;
        exp_gnt.push_back({SI, 64'h9000});
        exp_rsp.push_back({SI, 64'h9000 ^ KEY});
        @(negedge clk_i);
        chk("post_rst_err", err_o, 0);
        chk("post_rst_gnt", instr_if_data_gnt_o, 1);
        tick();
        instr_if_data_req_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_rvalid", instr_if_data_rvalid_o, 1);
        chk("post_rst_err2", err_o, 0);
        tick();
        tick();
        // rvalid with nothing outstanding
        inject_rv = 1'b1;
        inj_data = 64'h1234;
        @(negedge clk_i);
        chk("spurious_instr_rvalid", instr_if_data_rvalid_o, 0);
        chk("spurious_data_rvalid", data_if_data_rvalid_o, 0);
        tick();
        inject_rv = 1'b0;
        @(negedge clk_i);
        chk("err_set", err_o, 1);
        tick();
        tick();
        @(negedge clk_i);
        chk("err_held", err_o, 1);
        do_reset();
        @(negedge clk_i);
        chk("err_cleared", err_o, 0);
        chk("err_cleared_mem_req", mem_req_o, 0);
        tick();
        tick();
        tick();
        chk("gnt_queue_drained", 64'(exp_gnt.size()), 0);
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Two-to-one arbiter that shares a single req/gnt/rvalid memory port between the core's instruction-fetch interface and its data interface. It sits between the core and a single-ported memory (RAM/boot-ROM subsystem). It grants requesters round-robin, holds the winner while the memory stalls, and tracks outstanding transactions in order so each response returns to the port that issued it.

## Interface
- ADDR_WIDTH, 64, address width of all ports
- DATA_WIDTH, 64, data width; byte-enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory transactions (≥1)
- clk_i  in  1  clock; **one clock domain**
- rst_i  in  1  **asynchronous, active-high** reset
- instr_if_address_i  in  ADDR_WIDTH  fetch address
- instr_if_data_req_i  in  1  fetch request
- instr_if_data_gnt_o  out  1  fetch accepted
- instr_if_data_rvalid_o  out  1  fetch data valid
- instr_if_data_rdata_o  out  DATA_WIDTH  fetch data
- data_if_address_i  in  ADDR_WIDTH  data address
- data_if_data_req_i  in  1  data request
- data_if_data_we_i  in  1  write enable
- data_if_data_be_i  in  DATA_WIDTH/8  byte enables
- data_if_data_wdata_i  in  DATA_WIDTH  write data
- data_if_data_gnt_o  out  1  data accepted
- data_if_data_rvalid_o  out  1  data response valid (reads and writes)
- data_if_data_rdata_o  out  DATA_WIDTH  read data
- mem_address_o, mem_req_o, mem_we_o, mem_be_o, mem_wdata_o  out  memory request, widths as above
- mem_gnt_i, mem_rvalid_i  in  1  memory handshake
- mem_rdata_i  in  DATA_WIDTH  memory read data
- err_o  out  1  sticky protocol error (rvalid with nothing outstanding)

## Operation
- Handshake: a request transfers in the cycle mem_req_o & mem_gnt_i. Requesters hold req and payload until gnt.
- Selection: if only one port requests, it is selected. If both request, the port not granted last wins. The last-granted register (last_q) updates only on a handshake.
- Lock: if mem_req_o is high and mem_gnt_i is low, the selected source is latched (locked_q, lock_src_q). The selection stays fixed until that handshake completes, even if priority would flip.
- Forwarding: mem_* carries the selected port's payload. For an instruction fetch, we=0, be=all ones, and wdata=0.
- mem_req_o = (instr_req | data_req) & ~full. Requester gnt = mem_gnt_i & mem_req_o & (selected == that port).
- Response routing: on each handshake, the source id is pushed into an in-order FIFO of depth MAX_OUTSTANDING. On mem_rvalid_i, the head is popped and only the matching *_rvalid_o is asserted.
- Both rdata outputs are driven with mem_rdata_i at all times. Only rvalid is routed.
- Full: when the FIFO is full, mem_req_o = 0 and both gnts = 0. This holds even if a pop occurs the same cycle, which keeps the request path free of rvalid.
- Empty plus mem_rvalid_i: no rvalid is forwarded and err_o sets. err_o clears only on reset.
- A push and pop in the same cycle (not full) are both performed, and the count is unchanged.

## Timing
- gnt and mem_req_o are combinational from the inputs and state (zero-cycle). *_rvalid_o is combinational from mem_rvalid_i.
- The arbiter adds no latency. Response latency equals memory latency (1 cycle for the current RAM/ROM).
- Reset values:
  - Outputs: all *_gnt_o = 0 and *_rvalid_o = 0 while no req or rvalid is present; err_o = 0.
  - State: FIFO empty, locked_q = 0, last_q = DATA, so the first conflict goes to instruction.
- Reset asserted mid-operation: the FIFO is flushed and the lock is dropped. Responses arriving after reset release with an empty FIFO set err_o, so the memory must also be reset.
- Back-to-back: a port may handshake every cycle while the FIFO is not full. Under a continuous conflict, grants alternate I, D, I, D.

## Structure
- Shared package core_mem_pkg holds:
  - typedef enum logic {SRC_INSTR, SRC_DATA} mem_src_e
  - MEM_MAX_OUTSTANDING default constant
- Sub-module id_fifo (parameterised width and depth, push/pop/full/empty, async active-high reset) stores mem_src_e ids.
- The arbiter and lock logic stay in core_mem_arbiter.

## Test plan
- Single instruction fetch at 0x1000 with 1-cycle memory -> instr gnt same cycle; instr rvalid next cycle with mem rdata; data rvalid stays 0.
- Both ports request continuously for 8 cycles with always-gnt memory -> grant order I,D,I,D,I,D,I,D; responses routed in that order.
- Data write (be=0x0F, wdata=0xDEADBEEF) while memory withholds gnt 3 cycles, and instr req rises in cycle 2 -> selection stays data until gnt; mem_we_o=1 and be=0x0F throughout; instr granted after.
- Memory never returns rvalid, MAX_OUTSTANDING=2 -> two handshakes accepted, then mem_req_o=0 and gnts=0 until the first rvalid.
- mem_rvalid_i pulse with an empty FIFO -> no port rvalid, err_o=1 and held; rst_i pulse -> err_o=0, FIFO empty.
- rst_i asserted with 2 outstanding -> after release, a fresh fetch is granted and routed correctly from an empty FIFO.
